// File: rtl/dmem_access_ctrl.sv
// Data-memory strobe initiator: sequences one setup/strobe/hold access per CPU request and
// folds the address precheck and memory status flags into a single response with an error bit.
module dmem_access_ctrl #(
   parameter int                ADDR_W     = 15,
   parameter int                DATA_W     = 64,
   parameter int                SETUP_CYC  = 1,
   parameter int                STROBE_CYC = 2,
   parameter int                HOLD_CYC   = 1,
   parameter logic [DATA_W-1:0] ERR_VALUE  = 64'hDEADBEEFDEADBEEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [63:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_error,
   output logic [7:0]        err_count,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wr_strobe,
   output logic              mem_rd_strobe,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_oob,
   input  logic              mem_conflict
);

   localparam int MAX_SS  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
   localparam int MAX_CYC = (MAX_SS > HOLD_CYC) ? MAX_SS : HOLD_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      RESP
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             is_write;

   logic       pre_err;
   logic       hold_err;
   logic [7:0] err_count_inc;

   // Byte address must be word aligned and fall inside the 2^ADDR_W word window.
   assign pre_err       = (|req_addr[2:0]) || (|req_addr[63:ADDR_W+3]);
   assign hold_err      = mem_oob | mem_conflict;
   assign err_count_inc = (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         is_write      <= 1'b0;
         req_ready     <= 1'b1;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_error     <= 1'b0;
         err_count     <= 8'd0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         mem_wr_strobe <= 1'b0;
         mem_rd_strobe <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  is_write  <= req_write;
                  mem_addr  <= req_addr[ADDR_W+2:3];
                  mem_wdata <= req_wdata;
                  if (pre_err) begin
                     // Rejected before any strobe: answer on the very next cycle.
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_error <= 1'b1;
                     rsp_rdata <= req_write ? '0 : ERR_VALUE;
                     err_count <= err_count_inc;
                  end else begin
                     state <= SETUP;
                     cnt   <= SETUP_LAST;
                  end
               end
            end

            SETUP: begin
               if (cnt == '0) begin
                  state         <= STROBE;
                  cnt           <= STROBE_LAST;
                  mem_wr_strobe <= is_write;
                  mem_rd_strobe <= !is_write;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            STROBE: begin
               if (cnt == '0) begin
                  state         <= HOLD;
                  cnt           <= HOLD_LAST;
                  mem_wr_strobe <= 1'b0;
                  mem_rd_strobe <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            HOLD: begin
               if (cnt == '0) begin
                  // Memory status and read data are captured on the edge closing the hold window.
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_error <= hold_err;
                  if (is_write)
                     rsp_rdata <= '0;
                  else if (hold_err)
                     rsp_rdata <= ERR_VALUE;
                  else
                     rsp_rdata <= mem_rdata;
                  if (hold_err)
                     err_count <= err_count_inc;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            RESP: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end

            default: begin
               state         <= IDLE;
               req_ready     <= 1'b1;
               rsp_valid     <= 1'b0;
               mem_wr_strobe <= 1'b0;
               mem_rd_strobe <= 1'b0;
            end
         endcase
      end
   end

endmodule
